stepper_step_sequencer: RTL and testbench

- Sits directly upstream of the step delay counter. Drives that counter's start, enable and delay inputs, and consumes its done output.
- Advances a 4-coil stepper phase pattern once per elapsed delay.
- Supports full-step and half-step modes, both directions, and either a programmed step count or continuous run.
- Receives commands from the top-level control logic.

---
 rtl/stepper_step_sequencer.sv | 119 +++++++++++
 tb/tb_stepper_step_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_step_sequencer.sv
// Stepper phase sequencer: walks a 4-coil, 8-entry phase table once per elapsed
// step delay, in full/half-step, either direction, counted or continuous.
module stepper_step_sequencer #(
  parameter bit HOLD_TORQUE = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             stop,
  input  logic             dir,
  input  logic             half_step,
  input  logic [CNT_W-1:0] num_steps,
  input  logic [7:0]       step_delay,
  input  logic             delay_done,
  output logic             dly_start,
  output logic             dly_enable,
  output logic [7:0]       dly_value,
  output logic [3:0]       coils,
  output logic             busy,
  output logic             step_pulse,
  output logic             done_pulse,
  output logic [CNT_W-1:0] remaining,
  output logic [2:0]       fsm_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WAIT = 3'd2,
    STEP = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t     state, state_nx;
  logic [2:0] idx;
  logic [2:0] idx_step;
  logic       run_dir, run_half, run_cont;

  function automatic logic [3:0] phase_of(input logic [2:0] i);
    case (i)
      3'd0:    phase_of = 4'b1000;
      3'd1:    phase_of = 4'b1100;
      3'd2:    phase_of = 4'b0100;
      3'd3:    phase_of = 4'b0110;
      3'd4:    phase_of = 4'b0010;
      3'd5:    phase_of = 4'b0011;
      3'd6:    phase_of = 4'b0001;
      default: phase_of = 4'b1001;
    endcase
  endfunction

  // 3-bit index arithmetic gives the mod-8 wrap for free.
  assign idx_step = run_dir ? idx + (run_half ? 3'd1 : 3'd2)
                            : idx - (run_half ? 3'd1 : 3'd2);

  // Valid/ready-free control: go is a one-cycle request honoured only in IDLE,
  // stop is a level abort, delay_done is a level seen only while in WAIT.
  always_comb begin
    state_nx   = state;
    dly_start  = 1'b0;
    dly_enable = 1'b0;
    step_pulse = 1'b0;
    done_pulse = 1'b0;
    case (state)
      IDLE: if (go && !stop) state_nx = LOAD;
      LOAD: begin
        dly_start = 1'b1;
        state_nx  = stop ? IDLE : WAIT;
      end
      WAIT: begin
        dly_enable = 1'b1;
        if (stop)            state_nx = IDLE;
        else if (delay_done) state_nx = STEP;
      end
      STEP: begin
        step_pulse = 1'b1;
        if (stop)                                          state_nx = IDLE;
        else if (!run_cont && remaining == CNT_W'(1))      state_nx = DONE;
        else                                               state_nx = LOAD;
      end
      DONE: begin
        done_pulse = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 3'd0;
      remaining <= '0;
      dly_value <= 8'd0;
      run_dir   <= 1'b0;
      run_half  <= 1'b0;
      run_cont  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && go && !stop) begin
        run_dir   <= dir;
        run_half  <= half_step;
        run_cont  <= (num_steps == '0);
        dly_value <= step_delay;
        remaining <= num_steps;
      end
      if (state == STEP) begin
        idx <= idx_step;
        if (!run_cont && remaining != '0) remaining <= remaining - CNT_W'(1);
      end
    end
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;
  assign coils     = (HOLD_TORQUE || busy) ? phase_of(idx) : 4'b0000;

endmodule

// File: tb/tb_stepper_step_sequencer.sv
// Bench for stepper_step_sequencer: delay-counter stub, per-step coil/remaining
// scoreboard, directed runs for counted, continuous, stop, go-ignore and reset.
module tb_stepper_step_sequencer;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             go = 1'b0, stop = 1'b0, dir = 1'b0, half_step = 1'b0;
  logic [CNT_W-1:0] num_steps = '0;
  logic [7:0]       step_delay = 8'd0;
  logic             delay_done;
  logic             dly_start, dly_enable, busy, step_pulse, done_pulse;
  logic [7:0]       dly_value;
  logic [3:0]       coils;
  logic [CNT_W-1:0] remaining;
  logic [2:0]       fsm_state;

  // delay counter stub
  logic [7:0] stub_cnt;
  logic [7:0] stub_delay = 8'd2;
  logic       stub_use_val = 1'b0;

  int n_checks = 0, n_errors = 0;
  logic [3:0]       exp_coils_q[$];
  logic [CNT_W-1:0] exp_rem_q[$];
  int   done_cnt = 0, start_cnt = 0;
  logic prev_step = 1'b0;
  int   model_idx = 0;

  stepper_step_sequencer #(.HOLD_TORQUE(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .go(go), .stop(stop), .dir(dir),
    .half_step(half_step), .num_steps(num_steps), .step_delay(step_delay),
    .delay_done(delay_done), .dly_start(dly_start), .dly_enable(dly_enable),
    .dly_value(dly_value), .coils(coils), .busy(busy), .step_pulse(step_pulse),
    .done_pulse(done_pulse), .remaining(remaining), .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset)                stub_cnt <= 8'd0;
    else if (dly_start)       stub_cnt <= stub_use_val ? dly_value : stub_delay;
    else if (stub_cnt != 8'd0) stub_cnt <= stub_cnt - 8'd1;
  end
  assign delay_done = (stub_cnt == 8'd1);

  function automatic logic [3:0] phase_of(input int i);
    case (i)
      0: phase_of = 4'b1000; 1: phase_of = 4'b1100;
      2: phase_of = 4'b0100; 3: phase_of = 4'b0110;
      4: phase_of = 4'b0010; 5: phase_of = 4'b0011;
      6: phase_of = 4'b0001; default: phase_of = 4'b1001;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: push the coil pattern and remaining count after each step.
  task automatic model_push(input int n, input logic d, input logic h, input bit cont);
    int inc;
    inc = h ? 1 : 2;
    for (int k = 1; k <= n; k++) begin
      model_idx = d ? (model_idx + inc) % 8 : (model_idx + 8 - inc) % 8;
      exp_coils_q.push_back(phase_of(model_idx));
      exp_rem_q.push_back(cont ? '0 : CNT_W'(n - k));
    end
  endtask

  // scoreboard monitor: coils/remaining are compared the cycle after STEP
  always @(negedge clk) begin
    if (reset) begin
      prev_step = 1'b0;
    end else begin
      if (prev_step) begin
        check("sb_underflow", exp_coils_q.size() != 0, 1);
        if (exp_coils_q.size() != 0) begin
          check("step_coils", coils, exp_coils_q.pop_front());
          check("step_remaining", remaining, exp_rem_q.pop_front());
        end
      end
      prev_step = step_pulse;
      if (done_pulse) done_cnt++;
      if (dly_start)  start_cnt++;
    end
  end

  // driver tasks
  task automatic start_run(input int n, input logic d, input logic h,
                           input logic [7:0] dly, input logic [7:0] sd);
    @(negedge clk);
    num_steps = CNT_W'(n); dir = d; half_step = h; step_delay = dly;
    stub_delay = sd; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int c;
    c = 0;
    while (busy && c < budget) begin @(negedge clk); c++; end
    check(tag, c < budget, 1);
  endtask

  task automatic wait_enable(input int budget, input string tag);
    int c;
    c = 0;
    while (!dly_enable && c < budget) begin @(negedge clk); c++; end
    check(tag, c < budget, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    model_idx = 0;
  endtask

  initial begin
    int d0, s0, k, c;

    // reset state
    @(negedge clk); @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_coils", coils, 4'b1000);
    check("rst_remaining", remaining, 0);
    check("rst_dly_value", dly_value, 0);
    check("rst_state", fsm_state, 0);
    check("rst_pulses", {dly_start, dly_enable, step_pulse, done_pulse}, 0);
    #1 reset = 1'b0;

    // counted half-step forward run
    d0 = done_cnt;
    model_push(4, 1'b1, 1'b1, 1'b0);
    start_run(4, 1'b1, 1'b1, 8'd3, 8'd5);
    check("t1_remaining_latched", remaining, 4);
    check("t1_dly_value", dly_value, 3);
    wait_idle(200, "t1_timeout");
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_busy", busy, 0);
    check("t1_hold_coils", coils, 4'b0010);

    // counted full-step reverse run from index 0 (wrap 0->6->4->2)
    do_reset();
    d0 = done_cnt;
    model_push(3, 1'b0, 1'b0, 1'b0);
    start_run(3, 1'b0, 1'b0, 8'd2, 8'd3);
    wait_idle(200, "t2_timeout");
    check("t2_done_count", done_cnt - d0, 1);
    check("t2_final_coils", coils, 4'b0100);

    // continuous run, stop in WAIT after 10 steps
    d0 = done_cnt;
    model_push(10, 1'b1, 1'b0, 1'b1);
    start_run(0, 1'b1, 1'b0, 8'd2, 8'd2);
    k = 0; c = 0;
    while (k < 10 && c < 500) begin
      if (step_pulse) k++;
      if (k < 10) @(negedge clk);
      c++;
    end
    check("t3_ten_steps", k, 10);
    wait_enable(20, "t3_wait_timeout");
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t3_busy_after_stop", busy, 0);
    check("t3_enable_after_stop", dly_enable, 0);
    check("t3_remaining", remaining, 0);
    repeat (4) @(negedge clk);
    check("t3_no_done", done_cnt - d0, 0);
    check("t3_no_extra_busy", busy, 0);

    // go with stop in IDLE is ignored
    @(negedge clk);
    num_steps = CNT_W'(5); go = 1'b1; stop = 1'b1;
    @(negedge clk);
    go = 1'b0; stop = 1'b0;
    check("t4_go_stop_busy", busy, 0);
    @(negedge clk);
    check("t4_go_stop_busy2", busy, 0);

    // go during WAIT is ignored, num_steps not relatched
    d0 = done_cnt;
    model_push(2, 1'b1, 1'b1, 1'b0);
    start_run(2, 1'b1, 1'b1, 8'd4, 8'd4);
    wait_enable(20, "t4_wait_timeout");
    num_steps = CNT_W'(9); go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("t4_remaining_kept", remaining, 2);
    wait_idle(200, "t4_timeout");
    check("t4_done_count", done_cnt - d0, 1);
    check("t4_remaining_end", remaining, 0);

    // asynchronous reset mid-WAIT
    model_push(3, 1'b1, 1'b0, 1'b0);
    start_run(3, 1'b1, 1'b0, 8'd9, 8'd8);
    wait_enable(20, "t5_wait_timeout");
    #2 reset = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_coils", coils, 4'b1000);
    check("t5_remaining", remaining, 0);
    check("t5_enable", dly_enable, 0);
    exp_coils_q.delete();
    exp_rem_q.delete();
    model_idx = 0;
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (12) @(negedge clk);
    check("t5_no_step_after_reset", {busy, step_pulse}, 0);
    check("t5_coils_hold", coils, 4'b1000);

    // stub driven by dly_value, two steps
    stub_use_val = 1'b1;
    s0 = start_cnt;
    model_push(2, 1'b1, 1'b1, 1'b0);
    start_run(2, 1'b1, 1'b1, 8'd4, 8'd0);
    wait_enable(20, "t6_wait_timeout");
    check("t6_done_low_on_entry", delay_done, 0);
    check("t6_dly_value", dly_value, 4);
    check("t6_coils_before_step", coils, 4'b1000);
    wait_idle(200, "t6_timeout");
    check("t6_start_count", start_cnt - s0, 2);

    @(negedge clk);
    check("sb_coils_empty", exp_coils_q.size(), 0);
    check("sb_rem_empty", exp_rem_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no end expected end");
    $fatal(1, "global timeout");
  end

endmodule
